// File: rtl/min_receive_fsm.sv
// MIN frame receiver: SOF detection, byte destuffing, header/payload capture, optional CRC32 check.
// Define MIN_RX_CRC_CHECK_EN to compute and check the reflected CRC32; otherwise the CRC bytes are only consumed.
module min_receive_fsm #(
  parameter int N_DATA_BYTE = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [7:0]               i_data,
  output logic                     o_valid,
  output logic [7:0]               o_id,
  output logic [3:0]               o_len,
  output logic [8*N_DATA_BYTE-1:0] o_data,
  output logic                     o_err,
  output logic [2:0]               o_dbg_state
);

  // Handshake: i_valid qualifies i_data for exactly one cycle; there is no backpressure.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ID      = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CRC     = 3'd4;
  localparam logic [2:0] S_EOF     = 3'd5;

  localparam logic [7:0] MAX_LEN = 8'(N_DATA_BYTE);
  localparam int         DW      = 8 * N_DATA_BYTE;

  logic [2:0]    state_q, state_d;
  logic [1:0]    aa_cnt_q, aa_cnt_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    id_w_q, id_w_d;
  logic [3:0]    len_w_q, len_w_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [7:0]    id_q, id_d;
  logic [3:0]    len_q, len_d;
  logic [DW-1:0] data_q, data_d;
  logic          crc_ok;

`ifdef MIN_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;
  logic [31:0] rx_crc_q, rx_crc_d;
  logic [31:0] crc_upd;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_upd = crc_next(crc_q, i_data);
  assign crc_ok  = (~crc_q) == rx_crc_q;
`else
  assign crc_ok  = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    aa_cnt_d = aa_cnt_q;
    cnt_d    = cnt_q;
    id_w_d   = id_w_q;
    len_w_d  = len_w_q;
    buf_d    = buf_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    id_d     = id_q;
    len_d    = len_q;
    data_d   = data_q;
`ifdef MIN_RX_CRC_CHECK_EN
    crc_d    = crc_q;
    rx_crc_d = rx_crc_q;
`endif
    if (i_valid) begin
      if (i_data == 8'hAA && aa_cnt_q == 2'd2) begin
        // Third 0xAA restarts decoding from any state; an interrupted frame is reported.
        state_d  = S_ID;
        aa_cnt_d = 2'd0;
        cnt_d    = 4'd0;
        buf_d    = '0;
        err_d    = (state_q != S_IDLE);
`ifdef MIN_RX_CRC_CHECK_EN
        crc_d    = 32'hFFFF_FFFF;
`endif
      end else if (i_data == 8'h55 && aa_cnt_q == 2'd2 && state_q != S_IDLE) begin
        aa_cnt_d = 2'd0;
      end else begin
        aa_cnt_d = (i_data == 8'hAA) ? aa_cnt_q + 2'd1 : 2'd0;
        case (state_q)
          S_ID: begin
            id_w_d  = i_data;
            state_d = S_LEN;
`ifdef MIN_RX_CRC_CHECK_EN
            crc_d   = crc_upd;
`endif
          end
          S_LEN: begin
            len_w_d = i_data[3:0];
            cnt_d   = 4'd0;
`ifdef MIN_RX_CRC_CHECK_EN
            crc_d   = crc_upd;
`endif
            if (i_data > MAX_LEN) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else if (i_data == 8'h00) begin
              state_d = S_CRC;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            // Byte 0 lands in the most significant byte of the buffer.
            for (int i = 0; i < N_DATA_BYTE; i++) begin
              if (cnt_q == 4'(i)) buf_d[DW-1-8*i -: 8] = i_data;
            end
`ifdef MIN_RX_CRC_CHECK_EN
            crc_d = crc_upd;
`endif
            if (cnt_q + 4'd1 == len_w_q) begin
              cnt_d   = 4'd0;
              state_d = S_CRC;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          S_CRC: begin
`ifdef MIN_RX_CRC_CHECK_EN
            rx_crc_d = {rx_crc_q[23:0], i_data};
`endif
            if (cnt_q == 4'd3) begin
              cnt_d   = 4'd0;
              state_d = S_EOF;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          S_EOF: begin
            state_d = S_IDLE;
            if (i_data == 8'h55 && crc_ok) begin
              valid_d = 1'b1;
              id_d    = id_w_q;
              len_d   = len_w_q;
              data_d  = buf_q;
            end else begin
              err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      aa_cnt_q <= 2'd0;
      cnt_q    <= 4'd0;
      id_w_q   <= 8'd0;
      len_w_q  <= 4'd0;
      buf_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      id_q     <= 8'd0;
      len_q    <= 4'd0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      aa_cnt_q <= aa_cnt_d;
      cnt_q    <= cnt_d;
      id_w_q   <= id_w_d;
      len_w_q  <= len_w_d;
      buf_q    <= buf_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      id_q     <= id_d;
      len_q    <= len_d;
      data_q   <= data_d;
    end
  end

`ifdef MIN_RX_CRC_CHECK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      crc_q    <= 32'hFFFF_FFFF;
      rx_crc_q <= 32'h0;
    end else begin
      crc_q    <= crc_d;
      rx_crc_q <= rx_crc_d;
    end
  end
`endif

  assign o_valid     = valid_q;
  assign o_err       = err_q;
  assign o_id        = id_q;
  assign o_len       = len_q;
  assign o_data      = data_q;
  assign o_dbg_state = state_q;

endmodule
